// File: rtl/mem_stage_unit.sv
// MEM stage of the 5-stage RISC-V core: drives loads/stores on a req/ack data
// bus with optional timeout, resolves branch/JALR redirects and owns MEM/WB.
module mem_stage_unit #(
    parameter int NBits          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NBits-1:0] EX_MEM_pc_4_i,
    input  logic [NBits-1:0] EX_MEM_pc_i,
    input  logic             EX_MEM_zero_i,
    input  logic [NBits-1:0] EX_MEM_alu_result_i,
    input  logic [NBits-1:0] EX_MEM_write_data_i,
    input  logic [4:0]       EX_MEM_write_register_i,
    input  logic             EX_MEM_reg_write_i,
    input  logic [1:0]       EX_MEM_mem_to_reg_i,
    input  logic             EX_MEM_jalr_i,
    input  logic             EX_MEM_branch_i,
    input  logic             EX_MEM_mem_read_i,
    input  logic             EX_MEM_mem_write_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [NBits-1:0] dmem_addr_o,
    output logic [NBits-1:0] dmem_wdata_o,
    input  logic [NBits-1:0] dmem_rdata_i,
    input  logic             dmem_ack_i,
    output logic             stall_o,
    output logic             pc_src_o,
    output logic [NBits-1:0] pc_target_o,
    output logic             err_o,
    output logic [NBits-1:0] MEM_WB_read_data_o,
    output logic [NBits-1:0] MEM_WB_alu_result_o,
    output logic [NBits-1:0] MEM_WB_pc_4_o,
    output logic [4:0]       MEM_WB_write_register_o,
    output logic             MEM_WB_reg_write_o,
    output logic [1:0]       MEM_WB_mem_to_reg_o
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT =
        (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_t           state, state_d;
    logic [CW-1:0]    count, count_d;
    logic             err_d;
    logic             req_d, we_d;
    logic [NBits-1:0] addr_d, wdata_d;
    logic [NBits-1:0] wb_read_data_d, wb_alu_result_d, wb_pc_4_d;
    logic [4:0]       wb_write_register_d;
    logic             wb_reg_write_d;
    logic [1:0]       wb_mem_to_reg_d;
    logic             mem_op;
    logic             timeout_hit;

    assign mem_op      = EX_MEM_mem_read_i | EX_MEM_mem_write_i;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count == LAST_COUNT);

    // Redirect is purely combinational; branch/JALR never carry a memory op.
    assign pc_src_o    = (EX_MEM_branch_i & EX_MEM_zero_i) | EX_MEM_jalr_i;
    assign pc_target_o = EX_MEM_jalr_i ? {EX_MEM_alu_result_i[NBits-1:1], 1'b0}
                                       : EX_MEM_pc_i;

    always_comb begin
        state_d             = state;
        count_d             = count;
        err_d               = err_o;
        req_d               = dmem_req_o;
        we_d                = dmem_we_o;
        addr_d              = dmem_addr_o;
        wdata_d             = dmem_wdata_o;
        wb_read_data_d      = MEM_WB_read_data_o;
        wb_alu_result_d     = MEM_WB_alu_result_o;
        wb_pc_4_d           = MEM_WB_pc_4_o;
        wb_write_register_d = MEM_WB_write_register_o;
        wb_reg_write_d      = MEM_WB_reg_write_o;
        wb_mem_to_reg_d     = MEM_WB_mem_to_reg_o;
        stall_o             = 1'b0;

        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall_o        = 1'b1;
                    req_d          = 1'b1;
                    we_d           = EX_MEM_mem_write_i;
                    addr_d         = EX_MEM_alu_result_i;
                    wdata_d        = EX_MEM_write_data_i;
                    count_d        = '0;
                    wb_reg_write_d = 1'b0;
                    state_d        = ACCESS;
                end else begin
                    wb_read_data_d      = '0;
                    wb_alu_result_d     = EX_MEM_alu_result_i;
                    wb_pc_4_d           = EX_MEM_pc_4_i;
                    wb_write_register_d = EX_MEM_write_register_i;
                    wb_reg_write_d      = EX_MEM_reg_write_i;
                    wb_mem_to_reg_d     = EX_MEM_mem_to_reg_i;
                end
            end
            ACCESS: begin
                stall_o = !dmem_ack_i;
                // Ack takes priority over a timeout landing in the same cycle.
                if (dmem_ack_i || timeout_hit) begin
                    req_d               = 1'b0;
                    wb_read_data_d      = (dmem_ack_i && !dmem_we_o) ? dmem_rdata_i : '0;
                    wb_alu_result_d     = EX_MEM_alu_result_i;
                    wb_pc_4_d           = EX_MEM_pc_4_i;
                    wb_write_register_d = EX_MEM_write_register_i;
                    wb_reg_write_d      = EX_MEM_reg_write_i;
                    wb_mem_to_reg_d     = EX_MEM_mem_to_reg_i;
                    state_d             = IDLE;
                    if (!dmem_ack_i) begin
                        stall_o = 1'b0;
                        err_d   = 1'b1;
                    end
                end else begin
                    count_d        = count + 1'b1;
                    wb_reg_write_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                   <= IDLE;
            count                   <= '0;
            err_o                   <= 1'b0;
            dmem_req_o              <= 1'b0;
            dmem_we_o               <= 1'b0;
            dmem_addr_o             <= '0;
            dmem_wdata_o            <= '0;
            MEM_WB_read_data_o      <= '0;
            MEM_WB_alu_result_o     <= '0;
            MEM_WB_pc_4_o           <= '0;
            MEM_WB_write_register_o <= '0;
            MEM_WB_reg_write_o      <= 1'b0;
            MEM_WB_mem_to_reg_o     <= '0;
        end else begin
            state                   <= state_d;
            count                   <= count_d;
            err_o                   <= err_d;
            dmem_req_o              <= req_d;
            dmem_we_o               <= we_d;
            dmem_addr_o             <= addr_d;
            dmem_wdata_o            <= wdata_d;
            MEM_WB_read_data_o      <= wb_read_data_d;
            MEM_WB_alu_result_o     <= wb_alu_result_d;
            MEM_WB_pc_4_o           <= wb_pc_4_d;
            MEM_WB_write_register_o <= wb_write_register_d;
            MEM_WB_reg_write_o      <= wb_reg_write_d;
            MEM_WB_mem_to_reg_o     <= wb_mem_to_reg_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit with a 4-cycle access timeout.
module tb_mem_stage_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_4, pc, alu_result, write_data, rdata;
    logic        zero, reg_write, jalr, branch, mem_read, mem_write, ack;
    logic [4:0]  write_register;
    logic [1:0]  mem_to_reg;
    logic        dmem_req, dmem_we, stall, pc_src, err;
    logic [31:0] dmem_addr, dmem_wdata, pc_target;
    logic [31:0] wb_read_data, wb_alu_result, wb_pc_4;
    logic [4:0]  wb_write_register;
    logic        wb_reg_write;
    logic [1:0]  wb_mem_to_reg;

    int checks = 0;
    int errors = 0;

    mem_stage_unit #(.NBits(32), .TIMEOUT_CYCLES(4)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .EX_MEM_pc_4_i           (pc_4),
        .EX_MEM_pc_i             (pc),
        .EX_MEM_zero_i           (zero),
        .EX_MEM_alu_result_i     (alu_result),
        .EX_MEM_write_data_i     (write_data),
        .EX_MEM_write_register_i (write_register),
        .EX_MEM_reg_write_i      (reg_write),
        .EX_MEM_mem_to_reg_i     (mem_to_reg),
        .EX_MEM_jalr_i           (jalr),
        .EX_MEM_branch_i         (branch),
        .EX_MEM_mem_read_i       (mem_read),
        .EX_MEM_mem_write_i      (mem_write),
        .dmem_req_o              (dmem_req),
        .dmem_we_o               (dmem_we),
        .dmem_addr_o             (dmem_addr),
        .dmem_wdata_o            (dmem_wdata),
        .dmem_rdata_i            (rdata),
        .dmem_ack_i              (ack),
        .stall_o                 (stall),
        .pc_src_o                (pc_src),
        .pc_target_o             (pc_target),
        .err_o                   (err),
        .MEM_WB_read_data_o      (wb_read_data),
        .MEM_WB_alu_result_o     (wb_alu_result),
        .MEM_WB_pc_4_o           (wb_pc_4),
        .MEM_WB_write_register_o (wb_write_register),
        .MEM_WB_reg_write_o      (wb_reg_write),
        .MEM_WB_mem_to_reg_o     (wb_mem_to_reg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [31:0] p4, input logic [31:0] tgt,
                                 input logic [4:0] rd, input logic rw,
                                 input logic mr, input logic mw, input logic br,
                                 input logic jr, input logic z, input logic [1:0] m2r);
        alu_result     = alu;
        write_data     = wd;
        pc_4           = p4;
        pc             = tgt;
        write_register = rd;
        reg_write      = rw;
        mem_read       = mr;
        mem_write      = mw;
        branch         = br;
        jalr           = jr;
        zero           = z;
        mem_to_reg     = m2r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b0;
        ack   = 1'b0;
        rdata = '0;
        applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        #12;
        checkOutput("rst_req", dmem_req, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_wb_alu", wb_alu_result, 32'h0);
        checkOutput("rst_wb_rw", wb_reg_write, 1'b0);
        reset = 1'b1;

        // Plain ALU op passes straight into MEM/WB
        tick();
        applyStimulus(32'h1234, 32'h0, 32'h8, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        #1 checkOutput("alu_stall", stall, 1'b0);
        tick();
        checkOutput("alu_wb_alu", wb_alu_result, 32'h1234);
        checkOutput("alu_wb_rd", wb_write_register, 32'd5);
        checkOutput("alu_wb_rw", wb_reg_write, 1'b1);
        checkOutput("alu_wb_pc4", wb_pc_4, 32'h8);

        // Load at 0x100, three ACCESS cycles without ack, ack on the fourth
        applyStimulus(32'h100, 32'h0, 32'hC, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        #1 checkOutput("ld_stall_idle", stall, 1'b1);
        tick();
        checkOutput("ld_req", dmem_req, 1'b1);
        checkOutput("ld_addr", dmem_addr, 32'h100);
        checkOutput("ld_we", dmem_we, 1'b0);
        checkOutput("ld_bubble", wb_reg_write, 1'b0);
        checkOutput("ld_stall_a1", stall, 1'b1);
        tick();
        checkOutput("ld_stall_a2", stall, 1'b1);
        tick();
        checkOutput("ld_stall_a3", stall, 1'b1);
        checkOutput("ld_addr_held", dmem_addr, 32'h100);
        tick();
        ack   = 1'b1;
        rdata = 32'hDEADBEEF;
        #1 checkOutput("ld_stall_ack", stall, 1'b0);
        checkOutput("ld_req_ack", dmem_req, 1'b1);
        tick();
        ack   = 1'b0;
        rdata = 32'h0;
        checkOutput("ld_req_drop", dmem_req, 1'b0);
        checkOutput("ld_wb_data", wb_read_data, 32'hDEADBEEF);
        checkOutput("ld_wb_rw", wb_reg_write, 1'b1);
        checkOutput("ld_wb_rd", wb_write_register, 32'd7);
        checkOutput("ld_wb_m2r", wb_mem_to_reg, 32'd1);
        checkOutput("ld_err_ack_wins", err, 1'b0);

        // Back-to-back store at 0x200, acked in the first ACCESS cycle
        applyStimulus(32'h200, 32'hCAFEF00D, 32'h10, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        #1 checkOutput("st_stall_idle", stall, 1'b1);
        tick();
        checkOutput("st_we", dmem_we, 1'b1);
        checkOutput("st_wdata", dmem_wdata, 32'hCAFEF00D);
        checkOutput("st_addr", dmem_addr, 32'h200);
        checkOutput("st_hold_data", wb_read_data, 32'hDEADBEEF);
        ack   = 1'b1;
        rdata = 32'h55555555;
        #1 checkOutput("st_stall_ack", stall, 1'b0);
        tick();
        checkOutput("st_req_drop", dmem_req, 1'b0);
        checkOutput("st_wb_data", wb_read_data, 32'h0);
        checkOutput("st_wb_alu", wb_alu_result, 32'h200);

        // Ack while IDLE with no memory op must not start anything
        applyStimulus(32'h4, 32'h0, 32'h14, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        ack = 1'b0;
        checkOutput("idle_ack_req", dmem_req, 1'b0);
        checkOutput("idle_ack_wb", wb_alu_result, 32'h4);

        // Load never acked: aborts after four ACCESS cycles
        applyStimulus(32'h300, 32'h0, 32'h18, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        tick();
        checkOutput("to_req_a1", dmem_req, 1'b1);
        checkOutput("to_stall_a1", stall, 1'b1);
        tick();
        tick();
        checkOutput("to_stall_a3", stall, 1'b1);
        tick();
        checkOutput("to_req_a4", dmem_req, 1'b1);
        checkOutput("to_stall_a4", stall, 1'b0);
        checkOutput("to_err_before", err, 1'b0);
        tick();
        checkOutput("to_req_drop", dmem_req, 1'b0);
        checkOutput("to_err", err, 1'b1);
        checkOutput("to_wb_data", wb_read_data, 32'h0);
        checkOutput("to_wb_alu", wb_alu_result, 32'h300);
        checkOutput("to_wb_rw", wb_reg_write, 1'b1);
        applyStimulus(32'h0, 32'h0, 32'h1C, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        checkOutput("to_err_sticky", err, 1'b1);

        // Redirect resolution
        applyStimulus(32'h0, 32'h0, 32'h0, 32'h80, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        #1 checkOutput("br_taken_src", pc_src, 1'b1);
        checkOutput("br_taken_tgt", pc_target, 32'h80);
        applyStimulus(32'h1003, 32'h0, 32'h0, 32'h80, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        #1 checkOutput("jalr_src", pc_src, 1'b1);
        checkOutput("jalr_tgt", pc_target, 32'h1002);
        applyStimulus(32'h0, 32'h0, 32'h0, 32'h80, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        #1 checkOutput("br_not_taken", pc_src, 1'b0);

        // Reset in the middle of an access abandons it
        tick();
        applyStimulus(32'h40, 32'h0, 32'h20, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        tick();
        checkOutput("rm_req", dmem_req, 1'b1);
        checkOutput("rm_addr", dmem_addr, 32'h40);
        #1 reset = 1'b0;
        #1 checkOutput("rm_req_drop", dmem_req, 1'b0);
        checkOutput("rm_addr_clr", dmem_addr, 32'h0);
        checkOutput("rm_err_clr", err, 1'b0);
        checkOutput("rm_wb_alu", wb_alu_result, 32'h0);
        checkOutput("rm_wb_pc4", wb_pc_4, 32'h0);
        checkOutput("rm_wb_rd", wb_write_register, 32'd0);
        applyStimulus(32'h55, 32'h0, 32'h24, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        #1 reset = 1'b1;
        tick();
        checkOutput("rm_idle_req", dmem_req, 1'b0);
        checkOutput("rm_idle_wb", wb_alu_result, 32'h55);
        checkOutput("rm_idle_rw", wb_reg_write, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
